ex_arith_unit: RTL and testbench
================================

# ex_arith_unit

Execute-stage arithmetic cluster of the five-stage MIPS pipeline. It bundles three functions: the main ALU that operates on forwarded ID/EX operands, a general 32-bit adder used for PC+4 and branch-target computation, and the branch-delay detector that tells the hazard unit when the instruction now in ID/EX is a taken branch. The ALU and adder are purely combinational. The branch-delay flag has a combinational output and a registered copy.

## Interface
- No parameters. The datapath width is fixed at 32 bits.
- `clk`  in  1  pipeline clock; only the registered delay flag uses it.
- `reset`  in  1  asynchronous, active-high; clears `delay_q`.
- `alu_a`  in  32  ALU operand A (forwarded rs value).
- `alu_b`  in  32  ALU operand B (forwarded rt value or sign-extended immediate).
- `alu_control`  in  4  operation select.
- `alu_result`  out  32  ALU result.
- `alu_zero`  out  1  high when `alu_result` == 0.
- `add_a`  in  32  adder operand.
- `add_b`  in  32  adder operand.
- `add_sum`  out  32  (`add_a` + `add_b`) mod 2^32.
- `id_ex_branch`  in  2  branch type held in ID/EX: 00 none, 01 beq, 10 bne, 11 reserved (treated as a branch).
- `id_ex_pc_src`  in  1  branch-taken decision latched in ID/EX.
- `delay`  out  1  combinational taken-branch-in-EX flag.
- `delay_q`  out  1  `delay` registered by one cycle.

## Operation
- ALU, selected by `alu_control`:
  - 0000 AND.
  - 0001 OR.
  - 0010 ADD.
  - 0011 XOR.
  - 0110 SUB (A−B).
  - 0111 SLT signed: 1 if $signed(A) < $signed(B), else 0.
  - 0101 SLTU: unsigned compare, result 1 or 0.
  - 1100 NOR: ~(A|B).
  - 1000 SLL: B << A[4:0].
  - 1001 SRL: B >> A[4:0], logical.
  - 1010 SRA: B >>> A[4:0], arithmetic.
  - 1101 LUI: {B[15:0], 16'h0}.
  - Every other code (0100, 1011, 1110, 1111) gives result 0.
- ALU arithmetic wraps modulo 2^32. No overflow or trap output exists.
- SLT and SLTU zero-extend the 1-bit outcome to 32 bits.
- `alu_zero` is derived from the final `alu_result`. An undefined opcode therefore gives `alu_zero` = 1.
- Adder: unsigned 32-bit sum. Carry out is discarded. No control inputs.
- Branch delay: `delay` = (`id_ex_branch` != 2'b00) & `id_ex_pc_src`.
- No internal state except the `delay_q` flop.

## Timing
- `alu_result`, `alu_zero`, `add_sum` and `delay` are combinational with zero-cycle latency. They must settle within one `clk` period, with no internal register in these paths.
- `delay_q` updates on the rising edge of `clk` to the value of `delay` just before the edge.
- `delay_q` resets to 0 immediately when `reset` rises, independent of `clk`.
- `delay_q` holds 0 for as long as `reset` is high.
- A reset asserted mid-stream clears only `delay_q`. Combinational outputs keep following their inputs during reset.
- Reset values:
  - `delay_q` = 0.
  - The other outputs are not reset; they reflect their current inputs.
- The first edge after `reset` deasserts samples `delay` normally.

## Test plan
- ALU arithmetic:
  - A=0x7FFFFFFF, B=1, ctrl 0010 → result 0x80000000, zero 0.
  - A=5, B=5, ctrl 0110 → result 0, zero 1.
- Compares:
  - A=0xFFFFFFFF, B=1, ctrl 0111 → result 1.
  - Same operands, ctrl 0101 → result 0.
- Shifts:
  - A=4, B=0x80000001, ctrl 1000 → 0x00000010.
  - Same operands, ctrl 1001 → 0x08000000.
  - Same operands, ctrl 1010 → 0xF8000000.
  - ctrl 1101 with B=0x00001234 → 0x12340000.
- Logic and undefined codes:
  - A=0xF0F0F0F0, B=0x0FF00FF0, AND → 0x00F000F0.
  - Same operands, OR → 0xFFF0FFF0.
  - Same operands, XOR → 0xFF00FF00.
  - Same operands, NOR → 0x000F000F.
  - ctrl 1111 → result 0, zero 1.
- Adder:
  - 0x00000004 + 0xFFFFFFFC → 0x00000000.
  - 0x00400000 + 0x00000010 → 0x00400010.
- Branch delay:
  - branch=01, pc_src=1 → delay 1; `delay_q` = 1 after the next edge.
  - branch=00, pc_src=1 → delay 0.
  - branch=10, pc_src=0 → delay 0.
  - Pulse `reset` between edges while `delay_q` = 1 → `delay_q` drops to 0 at once, without waiting for a clock edge.

Source files
------------

// File: rtl/ex_arith_unit_if.sv
// Signal bundle for the execute-stage arithmetic cluster: ALU operands and result,
// general adder operands and sum, and the branch-delay detector inputs and flags.
interface ex_arith_unit_if;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_control;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_sum;
  logic [1:0]  id_ex_branch;
  logic        id_ex_pc_src;
  logic        delay;
  logic        delay_q;

  // Pipeline side: drives operands and branch state, consumes results.
  modport master (
    output alu_a, alu_b, alu_control, add_a, add_b, id_ex_branch, id_ex_pc_src,
    input  alu_result, alu_zero, add_sum, delay, delay_q
  );

  // Arithmetic cluster side.
  modport slave (
    input  alu_a, alu_b, alu_control, add_a, add_b, id_ex_branch, id_ex_pc_src,
    output alu_result, alu_zero, add_sum, delay, delay_q
  );
endinterface

// File: rtl/ex_arith_unit.sv
// Execute-stage arithmetic cluster of the five-stage MIPS pipeline.
// Combinational ALU and PC/branch-target adder, plus a taken-branch-in-EX
// detector whose flag is also offered as a one-cycle registered copy.
module ex_arith_unit (
  input  logic           clk,
  input  logic           reset,
  ex_arith_unit_if.slave bus
);

  logic [31:0] alu_res;
  logic [4:0]  shamt;
  logic        delay_c;

  // Shift amounts come from the low five bits of operand A (MIPS sllv-style).
  assign shamt = bus.alu_a[4:0];

  // ALU operation select; unused codes produce zero so alu_zero reads high.
  always_comb begin
    alu_res = 32'd0;
    case (bus.alu_control)
      4'b0000: alu_res = bus.alu_a & bus.alu_b;
      4'b0001: alu_res = bus.alu_a | bus.alu_b;
      4'b0010: alu_res = bus.alu_a + bus.alu_b;
      4'b0011: alu_res = bus.alu_a ^ bus.alu_b;
      4'b0110: alu_res = bus.alu_a - bus.alu_b;
      4'b0111: alu_res = {31'd0, ($signed(bus.alu_a) < $signed(bus.alu_b))};
      4'b0101: alu_res = {31'd0, (bus.alu_a < bus.alu_b)};
      4'b1100: alu_res = ~(bus.alu_a | bus.alu_b);
      4'b1000: alu_res = bus.alu_b << shamt;
      4'b1001: alu_res = bus.alu_b >> shamt;
      4'b1010: alu_res = $unsigned($signed(bus.alu_b) >>> shamt);
      4'b1101: alu_res = {bus.alu_b[15:0], 16'h0000};
      default: alu_res = 32'd0;
    endcase
  end

  // Zero flag is taken from the final result, including undefined codes.
  always_comb begin
    bus.alu_result = alu_res;
    bus.alu_zero   = (alu_res == 32'd0);
  end

  // General adder; the carry out is intentionally dropped.
  always_comb begin
    bus.add_sum = bus.add_a + bus.add_b;
  end

  // Any non-zero branch type counts, including the reserved 2'b11 encoding.
  always_comb begin
    delay_c   = (bus.id_ex_branch != 2'b00) & bus.id_ex_pc_src;
    bus.delay = delay_c;
  end

  // Registered copy of the delay flag; cleared at once by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.delay_q <= 1'b0;
    end else begin
      bus.delay_q <= delay_c;
    end
  end

endmodule

// File: tb/tb_ex_arith_unit.sv
// Self-checking bench for ex_arith_unit: table-driven ALU and adder vectors
// through an expected-value queue, plus hand sequences for the delay flag.
module tb_ex_arith_unit;

  logic clk;
  logic reset;

  ex_arith_unit_if bus ();

  ex_arith_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_zero;
  } alu_vec_t;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_sum;
  } add_vec_t;

  typedef struct {
    string       name;
    logic [31:0] val;
  } sb_t;

  sb_t sb[$];
  int  pass_cnt  = 0;
  int  total_cnt = 0;

  alu_vec_t alu_vecs[20];
  add_vec_t add_vecs[3];

  task automatic push_exp(input string name, input logic [31:0] val);
    sb_t e;
    e.name = name;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] act);
    sb_t e;
    total_cnt++;
    if (sb.size() == 0) begin
      $display("FAIL scoreboard_empty actual=%h", act);
    end else begin
      e = sb.pop_front();
      if (act === e.val) pass_cnt++;
      else $display("FAIL %s actual=%h expected=%h", e.name, act, e.val);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%b expected=%b", name, act, exp);
  endtask

  initial begin
    alu_vecs[0]  = '{"add_wrap",  4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0};
    alu_vecs[1]  = '{"sub_zero",  4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1};
    alu_vecs[2]  = '{"sub_neg",   4'b0110, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0};
    alu_vecs[3]  = '{"slt_neg",   4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
    alu_vecs[4]  = '{"sltu_big",  4'b0101, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
    alu_vecs[5]  = '{"slt_pos",   4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1};
    alu_vecs[6]  = '{"sltu_sml",  4'b0101, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 1'b0};
    alu_vecs[7]  = '{"sll",       4'b1000, 32'h00000004, 32'h80000001, 32'h00000010, 1'b0};
    alu_vecs[8]  = '{"srl",       4'b1001, 32'h00000004, 32'h80000001, 32'h08000000, 1'b0};
    alu_vecs[9]  = '{"sra",       4'b1010, 32'h00000004, 32'h80000001, 32'hF8000000, 1'b0};
    alu_vecs[10] = '{"sra_pos",   4'b1010, 32'h0000001F, 32'h7FFFFFFF, 32'h00000000, 1'b1};
    alu_vecs[11] = '{"sll_amt5",  4'b1000, 32'h00000021, 32'h00000001, 32'h00000002, 1'b0};
    alu_vecs[12] = '{"lui",       4'b1101, 32'hDEADBEEF, 32'hABCD1234, 32'h12340000, 1'b0};
    alu_vecs[13] = '{"and",       4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0};
    alu_vecs[14] = '{"or",        4'b0001, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 1'b0};
    alu_vecs[15] = '{"xor",       4'b0011, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0};
    alu_vecs[16] = '{"nor",       4'b1100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h000F000F, 1'b0};
    alu_vecs[17] = '{"undef_f",   4'b1111, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00000000, 1'b1};
    alu_vecs[18] = '{"undef_4",   4'b0100, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b1};
    alu_vecs[19] = '{"undef_b",   4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1};

    add_vecs[0] = '{"add_pc_wrap", 32'h00000004, 32'hFFFFFFFC, 32'h00000000};
    add_vecs[1] = '{"add_pc4",     32'h00400000, 32'h00000010, 32'h00400010};
    add_vecs[2] = '{"add_carry",   32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};

    reset            = 1'b1;
    bus.alu_a        = 32'd0;
    bus.alu_b        = 32'd0;
    bus.alu_control  = 4'b0000;
    bus.add_a        = 32'd0;
    bus.add_b        = 32'd0;
    bus.id_ex_branch = 2'b00;
    bus.id_ex_pc_src = 1'b0;

    // Reset state of the only flop.
    @(negedge clk);
    check1("reset_delay_q", bus.delay_q, 1'b0);

    // Combinational paths keep working during reset; delay_q stays cleared over an edge.
    bus.id_ex_branch = 2'b01;
    bus.id_ex_pc_src = 1'b1;
    #1;
    check1("delay_in_reset", bus.delay, 1'b1);
    @(posedge clk); #1;
    check1("delay_q_held_reset", bus.delay_q, 1'b0);

    // ALU vectors through the scoreboard.
    for (int i = 0; i < 20; i++) begin
      bus.alu_control = alu_vecs[i].ctrl;
      bus.alu_a       = alu_vecs[i].a;
      bus.alu_b       = alu_vecs[i].b;
      push_exp({alu_vecs[i].name, "_result"}, alu_vecs[i].exp_res);
      push_exp({alu_vecs[i].name, "_zero"}, {31'd0, alu_vecs[i].exp_zero});
      #1;
      pop_cmp(bus.alu_result);
      pop_cmp({31'd0, bus.alu_zero});
    end

    // Adder vectors plus a few random sums.
    for (int i = 0; i < 3; i++) begin
      bus.add_a = add_vecs[i].a;
      bus.add_b = add_vecs[i].b;
      push_exp(add_vecs[i].name, add_vecs[i].exp_sum);
      #1;
      pop_cmp(bus.add_sum);
    end
    for (int i = 0; i < 4; i++) begin
      bus.add_a = $urandom;
      bus.add_b = $urandom;
      push_exp("add_rand", bus.add_a + bus.add_b);
      #1;
      pop_cmp(bus.add_sum);
    end

    // Leave reset between edges; the first edge afterwards samples a taken beq.
    @(negedge clk);
    reset            = 1'b0;
    bus.id_ex_branch = 2'b01;
    bus.id_ex_pc_src = 1'b1;
    #1;
    check1("beq_taken_delay", bus.delay, 1'b1);
    check1("delay_q_before_edge", bus.delay_q, 1'b0);
    @(posedge clk); #1;
    check1("beq_taken_delay_q", bus.delay_q, 1'b1);

    // No branch type with pc_src high.
    @(negedge clk);
    bus.id_ex_branch = 2'b00;
    bus.id_ex_pc_src = 1'b1;
    #1;
    check1("none_delay", bus.delay, 1'b0);
    @(posedge clk); #1;
    check1("none_delay_q", bus.delay_q, 1'b0);

    // bne not taken, then taken, then reserved encoding taken.
    @(negedge clk);
    bus.id_ex_branch = 2'b10;
    bus.id_ex_pc_src = 1'b0;
    #1;
    check1("bne_not_taken", bus.delay, 1'b0);
    bus.id_ex_pc_src = 1'b1;
    #1;
    check1("bne_taken", bus.delay, 1'b1);
    bus.id_ex_branch = 2'b11;
    #1;
    check1("reserved_taken", bus.delay, 1'b1);
    @(posedge clk); #1;
    check1("reserved_delay_q", bus.delay_q, 1'b1);

    // Mid-period reset pulse clears delay_q without a clock edge.
    #1;
    reset = 1'b1;
    #1;
    check1("async_reset_clear", bus.delay_q, 1'b0);
    check1("delay_during_pulse", bus.delay, 1'b1);
    reset = 1'b0;
    #1;
    check1("cleared_until_edge", bus.delay_q, 1'b0);
    @(posedge clk); #1;
    check1("resample_after_pulse", bus.delay_q, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
